// File: rtl/noc_packetizer_if.sv
// Handshake bundle between a packet/payload source, the packetizer and the mesh node's
// local input port. master = the packetizer itself, slave = the source/node environment.
interface noc_packetizer_if #(
    parameter int COORD_W   = 4,
    parameter int LEN_W     = 4,
    parameter int PAYLOAD_W = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [COORD_W-1:0]   req_dst_x;
    logic [COORD_W-1:0]   req_dst_y;
    logic [LEN_W-1:0]     req_len;

    logic                 data_valid;
    logic                 data_ready;
    logic [PAYLOAD_W-1:0] data_i;

    logic [1:0]           flit_type_o;
    logic [PAYLOAD_W-1:0] flit_payload_o;
    logic                 enable_o;
    logic                 ack_i;

    modport master (
        input  req_valid, req_dst_x, req_dst_y, req_len,
        output req_ready,
        input  data_valid, data_i,
        output data_ready,
        output flit_type_o, flit_payload_o, enable_o,
        input  ack_i
    );

    modport slave (
        output req_valid, req_dst_x, req_dst_y, req_len,
        input  req_ready,
        output data_valid, data_i,
        input  data_ready,
        input  flit_type_o, flit_payload_o, enable_o,
        output ack_i
    );
endinterface

// File: rtl/noc_packetizer.sv
// Serialises a (destination, length) request plus payload words into HEADER/BODY/TAIL
// flits on a registered enable/ack port, at up to one flit per cycle.
module noc_packetizer #(
    parameter int COORD_W   = 4,
    parameter int LEN_W     = 4,
    parameter int PAYLOAD_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    noc_packetizer_if.master       bus,
    output logic                   busy_o,
    output logic [15:0]            pkt_sent_o
);

    localparam int XHI = 2*COORD_W + LEN_W - 1;
    localparam int XLO = COORD_W + LEN_W;
    localparam int YHI = COORD_W + LEN_W - 1;
    localparam int YLO = LEN_W;

    localparam logic [1:0] FT_HEADER = 2'd0;
    localparam logic [1:0] FT_BODY   = 2'd1;
    localparam logic [1:0] FT_TAIL   = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    if (PAYLOAD_W < 2*COORD_W + LEN_W) begin : g_bad_cfg
        $error("noc_packetizer: PAYLOAD_W too narrow for the header fields");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t               state_q,     state_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic                 enable_q,    enable_d;
    logic [1:0]           type_q,      type_d;
    logic [PAYLOAD_W-1:0] payload_q,   payload_d;
    logic                 last_q,      last_d;
    logic [15:0]          pkt_cnt_q,   pkt_cnt_d;

    logic slot_free_s;
    logic req_ready_s;
    logic data_ready_s;

    function automatic logic [PAYLOAD_W-1:0] make_header(
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [LEN_W-1:0]   len
    );
        logic [PAYLOAD_W-1:0] hdr;
        hdr          = {PAYLOAD_W{1'b0}};
        hdr[XHI:XLO] = dst_x;
        hdr[YHI:YLO] = dst_y;
        hdr[LEN_W-1:0] = len;
        return hdr;
    endfunction

    assign slot_free_s = !enable_q || bus.ack_i;

    // Next-state and handshake logic; last_q tags the flit that closes its packet.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        enable_d     = enable_q;
        type_d       = type_q;
        payload_d    = payload_q;
        last_d       = last_q;
        req_ready_s  = 1'b0;
        data_ready_s = 1'b0;

        if (slot_free_s) begin
            enable_d = 1'b0;
            last_d   = 1'b0;
        end else begin
            enable_d = enable_q;
        end

        case (state_q)
            S_IDLE: begin
                req_ready_s = slot_free_s && rst;
                if (bus.req_valid && req_ready_s) begin
                    enable_d    = 1'b1;
                    type_d      = FT_HEADER;
                    payload_d   = make_header(bus.req_dst_x, bus.req_dst_y, bus.req_len);
                    remaining_d = bus.req_len;
                    if (bus.req_len == LEN_ZERO) begin
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        last_d  = 1'b0;
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                data_ready_s = slot_free_s && rst;
                if (bus.data_valid && data_ready_s) begin
                    enable_d    = 1'b1;
                    payload_d   = bus.data_i;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        type_d  = FT_TAIL;
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        type_d  = FT_BODY;
                        last_d  = 1'b0;
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d  = S_IDLE;
                enable_d = 1'b0;
                last_d   = 1'b0;
            end
        endcase
    end

    // Completed-packet counter advances when the closing flit is acked.
    always_comb begin
        if (enable_q && bus.ack_i && last_q) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= LEN_ZERO;
            enable_q    <= 1'b0;
            type_q      <= FT_HEADER;
            payload_q   <= {PAYLOAD_W{1'b0}};
            last_q      <= 1'b0;
            pkt_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            enable_q    <= enable_d;
            type_q      <= type_d;
            payload_q   <= payload_d;
            last_q      <= last_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign bus.req_ready      = req_ready_s;
    assign bus.data_ready     = data_ready_s;
    assign bus.flit_type_o    = type_q;
    assign bus.flit_payload_o = payload_q;
    assign bus.enable_o       = enable_q;
    assign busy_o             = (state_q != S_IDLE) || enable_q;
    assign pkt_sent_o         = pkt_cnt_q;

endmodule
